// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: arbiter state encoding, dmem geometry
// and the byte-enable width also used by mem_pack.
package mem_pkg;

   localparam int DMEM_ADDR_WIDTH = 14;
   localparam int DMEM_BE_W       = 4;
   localparam int DMEM_DATA_W     = 32;

   typedef enum logic {
      S_CPU = 1'b0,
      S_AUX = 1'b1
   } arb_state_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational owner select for the shared dmem port; write enables are
// suppressed whenever the owner is not actually requesting.
module dmem_port_mux
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
   input  logic                   aux_sel,
   input  logic                   cpu_en,
   input  logic [DMEM_BE_W-1:0]   cpu_we,
   input  logic [ADDR_WIDTH-1:0]  cpu_addr,
   input  logic [DMEM_DATA_W-1:0] cpu_din,
   input  logic                   aux_valid,
   input  logic [DMEM_BE_W-1:0]   aux_we,
   input  logic [ADDR_WIDTH-1:0]  aux_addr,
   input  logic [DMEM_DATA_W-1:0] aux_din,
   output logic                   dmem_en,
   output logic [DMEM_BE_W-1:0]   dmem_we,
   output logic [ADDR_WIDTH-1:0]  dmem_addr,
   output logic [DMEM_DATA_W-1:0] dmem_din
);

   always_comb begin
      dmem_en   = aux_sel ? aux_valid : cpu_en;
      dmem_addr = aux_sel ? aux_addr  : cpu_addr;
      dmem_din  = aux_sel ? aux_din   : cpu_din;
      dmem_we   = '0;
      if (dmem_en)
         dmem_we = aux_sel ? aux_we : cpu_we;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single dmem port between the CPU mem stage and an aux requester.
// Define DMEM_ARB_STARVE_GUARD_EN to build the starvation guard (forced aux bursts).
module dmem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
   parameter int STARVE_LIMIT = 8,
   parameter int AUX_BURST    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpu_en,
   input  logic [DMEM_BE_W-1:0]   cpu_we,
   input  logic [ADDR_WIDTH-1:0]  cpu_addr,
   input  logic [DMEM_DATA_W-1:0] cpu_din,
   output logic                   cpu_stall,
   input  logic                   aux_req_valid,
   output logic                   aux_req_ready,
   input  logic [DMEM_BE_W-1:0]   aux_we,
   input  logic [ADDR_WIDTH-1:0]  aux_addr,
   input  logic [DMEM_DATA_W-1:0] aux_din,
   output logic                   aux_rvalid,
   output logic [DMEM_DATA_W-1:0] aux_rdata,
   output logic                   dmem_en,
   output logic [DMEM_BE_W-1:0]   dmem_we,
   output logic [ADDR_WIDTH-1:0]  dmem_addr,
   output logic [DMEM_DATA_W-1:0] dmem_din,
   input  logic [DMEM_DATA_W-1:0] dmem_dout
);

   if (STARVE_LIMIT < 1 || AUX_BURST < 1) begin : g_bad_cfg
      $error("dmem_arbiter: STARVE_LIMIT and AUX_BURST must be >= 1");
   end

   logic aux_sel;
   logic aux_accept;
   logic rd_vld_p1;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int BC_W = $clog2(AUX_BURST + 1);

   arb_state_t      state, state_nxt;
   logic [SC_W-1:0] starve_cnt, starve_nxt;
   logic [BC_W-1:0] burst_cnt, burst_nxt;

   // The forced grant takes effect in the cycle right after the limit-th blocked cycle.
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      burst_nxt  = burst_cnt;
      aux_sel    = !cpu_en;
      cpu_stall  = 1'b0;
      case (state)
         S_CPU: begin
            aux_sel = !cpu_en;
            if (!aux_req_valid || !cpu_en)
               starve_nxt = '0;
            else if (starve_cnt < SC_W'(STARVE_LIMIT))
               starve_nxt = starve_cnt + SC_W'(1);
            if (starve_nxt == SC_W'(STARVE_LIMIT)) begin
               state_nxt = S_AUX;
               burst_nxt = '0;
            end
         end
         S_AUX: begin
            aux_sel   = 1'b1;
            cpu_stall = cpu_en;
            if (!aux_req_valid) begin
               state_nxt  = S_CPU;
               starve_nxt = '0;
            end else begin
               burst_nxt = burst_cnt + BC_W'(1);
               if (burst_nxt == BC_W'(AUX_BURST)) begin
                  state_nxt  = S_CPU;
                  starve_nxt = '0;
               end
            end
         end
         default: state_nxt = S_CPU;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_CPU;
         starve_cnt <= '0;
         burst_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         burst_cnt  <= burst_nxt;
      end
   end
`else
   // Strict CPU priority: aux only ever sees cycles the CPU leaves idle.
   always_comb begin
      aux_sel   = !cpu_en;
      cpu_stall = 1'b0;
   end
`endif

   assign aux_accept    = aux_sel && aux_req_valid;
   assign aux_req_ready = aux_accept;

   // Stage p0 -> p1: dmem read data returns one cycle after an accepted aux read.
   always_ff @(posedge clk) begin
      if (rst)
         rd_vld_p1 <= 1'b0;
      else
         rd_vld_p1 <= aux_accept && (aux_we == '0);
   end

   assign aux_rvalid = rd_vld_p1;
   assign aux_rdata  = dmem_dout;

   dmem_port_mux #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_port_mux (
      .aux_sel   (aux_sel),
      .cpu_en    (cpu_en),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .aux_valid (aux_req_valid),
      .aux_we    (aux_we),
      .aux_addr  (aux_addr),
      .aux_din   (aux_din),
      .dmem_en   (dmem_en),
      .dmem_we   (dmem_we),
      .dmem_addr (dmem_addr),
      .dmem_din  (dmem_din)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous dmem model;
// starvation scenarios are selected by DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_en;
   logic [3:0]  cpu_we;
   logic [13:0] cpu_addr;
   logic [31:0] cpu_din;
   logic        cpu_stall;
   logic        aux_req_valid;
   logic        aux_req_ready;
   logic [3:0]  aux_we;
   logic [13:0] aux_addr;
   logic [31:0] aux_din;
   logic        aux_rvalid;
   logic [31:0] aux_rdata;
   logic        dmem_en;
   logic [3:0]  dmem_we;
   logic [13:0] dmem_addr;
   logic [31:0] dmem_din;
   logic [31:0] dmem_dout;

   logic [31:0] mem [0:255];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_WIDTH   (14),
      .STARVE_LIMIT (8),
      .AUX_BURST    (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_en        (cpu_en),
      .cpu_we        (cpu_we),
      .cpu_addr      (cpu_addr),
      .cpu_din       (cpu_din),
      .cpu_stall     (cpu_stall),
      .aux_req_valid (aux_req_valid),
      .aux_req_ready (aux_req_ready),
      .aux_we        (aux_we),
      .aux_addr      (aux_addr),
      .aux_din       (aux_din),
      .aux_rvalid    (aux_rvalid),
      .aux_rdata     (aux_rdata),
      .dmem_en       (dmem_en),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_din      (dmem_din),
      .dmem_dout     (dmem_dout)
   );

   // Read-first synchronous dmem with byte enables.
   always @(posedge clk) begin
      if (dmem_en) begin
         dmem_dout <= mem[dmem_addr[7:0]];
         for (int b = 0; b < 4; b++)
            if (dmem_we[b]) mem[dmem_addr[7:0]][8*b +: 8] <= dmem_din[8*b +: 8];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_en = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
      aux_req_valid = 0; aux_we = 0; aux_addr = 0; aux_din = 0;
   endtask

   task automatic conflict();
      cpu_en = 1; cpu_we = 0; cpu_addr = 14'h0020; cpu_din = 0;
      aux_req_valid = 1; aux_we = 0; aux_addr = 14'h0010; aux_din = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      step();
      step();
      n_checks++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", cpu_stall); else n_pass++;
      n_checks++; if (aux_req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", aux_req_ready); else n_pass++;
      n_checks++; if (dmem_en !== 1'b0) $display("FAIL reset_dmem_en: got %b want 0", dmem_en); else n_pass++;
      n_checks++; if (dmem_we !== 4'h0) $display("FAIL reset_dmem_we: got %h want 0", dmem_we); else n_pass++;
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", aux_rvalid); else n_pass++;
      // aux read accepted while rst is high must not produce rvalid
      aux_req_valid = 1; aux_addr = 14'h0010;
      step();
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL reset_cycle_read_rvalid: got %b want 0", aux_rvalid); else n_pass++;
      idle();
      rst = 0;
      step();
   endtask

   task automatic test_aux_only();
      aux_req_valid = 1; aux_we = 4'hF; aux_addr = 14'h0010; aux_din = 32'hDEADBEEF;
      #1;
      n_checks++; if (aux_req_ready !== 1'b1) $display("FAIL aux_wr_ready: got %b want 1", aux_req_ready); else n_pass++;
      n_checks++; if (dmem_we !== 4'hF) $display("FAIL aux_wr_we: got %h want f", dmem_we); else n_pass++;
      n_checks++; if (dmem_addr !== 14'h0010) $display("FAIL aux_wr_addr: got %h want 0010", dmem_addr); else n_pass++;
      n_checks++; if (dmem_din !== 32'hDEADBEEF) $display("FAIL aux_wr_din: got %h want deadbeef", dmem_din); else n_pass++;
      step();
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL aux_wr_no_rvalid: got %b want 0", aux_rvalid); else n_pass++;
      aux_we = 4'h0; aux_din = 32'h0;
      #1;
      n_checks++; if (aux_req_ready !== 1'b1) $display("FAIL aux_rd_ready: got %b want 1", aux_req_ready); else n_pass++;
      n_checks++; if (dmem_en !== 1'b1) $display("FAIL aux_rd_en: got %b want 1", dmem_en); else n_pass++;
      n_checks++; if (dmem_we !== 4'h0) $display("FAIL aux_rd_we: got %h want 0", dmem_we); else n_pass++;
      step();
      idle();
      n_checks++; if (aux_rvalid !== 1'b1) $display("FAIL aux_rd_rvalid: got %b want 1", aux_rvalid); else n_pass++;
      n_checks++; if (aux_rdata !== 32'hDEADBEEF) $display("FAIL aux_rd_data: got %h want deadbeef", aux_rdata); else n_pass++;
      step();
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL aux_rd_rvalid_drop: got %b want 0", aux_rvalid); else n_pass++;
   endtask

   task automatic test_idle_port();
      idle();
      cpu_we = 4'hF; aux_we = 4'hF;
      #1;
      n_checks++; if (dmem_en !== 1'b0) $display("FAIL idle_en: got %b want 0", dmem_en); else n_pass++;
      n_checks++; if (dmem_we !== 4'h0) $display("FAIL idle_we: got %h want 0", dmem_we); else n_pass++;
      n_checks++; if (aux_req_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", aux_req_ready); else n_pass++;
      step();
      idle();
   endtask

   task automatic test_cpu_priority();
      logic [31:0] vals [3];
      vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33334444;
      // CPU writes while aux is pending: CPU owns the port each cycle
      for (int i = 0; i < 3; i++) begin
         cpu_en = 1; cpu_we = 4'hF; cpu_addr = 14'h0040 + 14'(i); cpu_din = vals[i];
         aux_req_valid = 1; aux_we = 4'h0; aux_addr = 14'h0010;
         #1;
         n_checks++; if (dmem_din !== vals[i]) $display("FAIL cpu_wr_din[%0d]: got %h want %h", i, dmem_din, vals[i]); else n_pass++;
         n_checks++; if (dmem_we !== 4'hF) $display("FAIL cpu_wr_we[%0d]: got %h want f", i, dmem_we); else n_pass++;
         step();
      end
      // drop aux so the blocked-cycle count restarts before the read conflict
      idle();
      step();
      for (int c = 1; c <= 7; c++) begin
         conflict();
         #1;
         n_checks++; if (dmem_addr !== 14'h0020) $display("FAIL prio_addr[%0d]: got %h want 0020", c, dmem_addr); else n_pass++;
         n_checks++; if (dmem_en !== 1'b1) $display("FAIL prio_en[%0d]: got %b want 1", c, dmem_en); else n_pass++;
         n_checks++; if (aux_req_ready !== 1'b0) $display("FAIL prio_ready[%0d]: got %b want 0", c, aux_req_ready); else n_pass++;
         n_checks++; if (cpu_stall !== 1'b0) $display("FAIL prio_stall[%0d]: got %b want 0", c, cpu_stall); else n_pass++;
         step();
      end
      idle();
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33334444;
      for (int i = 0; i < 3; i++) begin
         aux_req_valid = 1; aux_we = 4'h0; aux_addr = 14'h0040 + 14'(i);
         #1;
         n_checks++; if (aux_req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, aux_req_ready); else n_pass++;
         step();
         n_checks++; if (aux_rvalid !== 1'b1) $display("FAIL b2b_rvalid[%0d]: got %b want 1", i, aux_rvalid); else n_pass++;
         n_checks++; if (aux_rdata !== vals[i]) $display("FAIL b2b_rdata[%0d]: got %h want %h", i, aux_rdata, vals[i]); else n_pass++;
      end
      idle();
      step();
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL b2b_rvalid_end: got %b want 0", aux_rvalid); else n_pass++;
      aux_req_valid = 1; aux_we = 4'b0011; aux_addr = 14'h0030; aux_din = 32'hAABBCCDD;
      #1;
      n_checks++; if (dmem_we !== 4'b0011) $display("FAIL partial_we: got %b want 0011", dmem_we); else n_pass++;
      step();
      idle();
      step();
   endtask

`ifdef DMEM_ARB_STARVE_GUARD_EN
   task automatic test_starvation();
      logic exp_force;
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         conflict();
         exp_force = (c >= 9);
         #1;
         n_checks++; if (cpu_stall !== exp_force) $display("FAIL starve_stall[%0d]: got %b want %b", c, cpu_stall, exp_force); else n_pass++;
         n_checks++; if (aux_req_ready !== exp_force) $display("FAIL starve_ready[%0d]: got %b want %b", c, aux_req_ready, exp_force); else n_pass++;
         n_checks++; if (dmem_addr !== (exp_force ? 14'h0010 : 14'h0020)) $display("FAIL starve_addr[%0d]: got %h want %h", c, dmem_addr, exp_force ? 14'h0010 : 14'h0020); else n_pass++;
         step();
         n_checks++; if (aux_rvalid !== exp_force) $display("FAIL starve_rvalid[%0d]: got %b want %b", c, aux_rvalid, exp_force); else n_pass++;
         if (exp_force) begin
            n_checks++; if (aux_rdata !== 32'hDEADBEEF) $display("FAIL starve_rdata[%0d]: got %h want deadbeef", c, aux_rdata); else n_pass++;
         end
      end
      // back in S_CPU with the blocked count restarted from zero
      for (int c = 13; c <= 20; c++) begin
         conflict();
         #1;
         n_checks++; if (cpu_stall !== 1'b0) $display("FAIL restart_stall[%0d]: got %b want 0", c, cpu_stall); else n_pass++;
         n_checks++; if (aux_req_ready !== 1'b0) $display("FAIL restart_ready[%0d]: got %b want 0", c, aux_req_ready); else n_pass++;
         step();
      end
      for (int c = 21; c <= 22; c++) begin
         conflict();
         #1;
         n_checks++; if (cpu_stall !== 1'b1) $display("FAIL early_stall[%0d]: got %b want 1", c, cpu_stall); else n_pass++;
         n_checks++; if (aux_req_ready !== 1'b1) $display("FAIL early_ready[%0d]: got %b want 1", c, aux_req_ready); else n_pass++;
         step();
      end
      aux_req_valid = 0;
      #1;
      n_checks++; if (cpu_stall !== 1'b1) $display("FAIL early_exit_stall: got %b want 1", cpu_stall); else n_pass++;
      n_checks++; if (dmem_en !== 1'b0) $display("FAIL early_exit_en: got %b want 0", dmem_en); else n_pass++;
      step();
      n_checks++; if (cpu_stall !== 1'b0) $display("FAIL early_after_stall: got %b want 0", cpu_stall); else n_pass++;
      n_checks++; if (dmem_addr !== 14'h0020) $display("FAIL early_after_addr: got %h want 0020", dmem_addr); else n_pass++;
      n_checks++; if (dmem_en !== 1'b1) $display("FAIL early_after_en: got %b want 1", dmem_en); else n_pass++;
      step();
      idle();
      step();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      conflict();
      for (int c = 1; c <= 8; c++) step();
      #1;
      n_checks++; if (cpu_stall !== 1'b1) $display("FAIL midrst_forced: got %b want 1", cpu_stall); else n_pass++;
      step();
      n_checks++; if (aux_rvalid !== 1'b1) $display("FAIL midrst_rvalid_pre: got %b want 1", aux_rvalid); else n_pass++;
      rst = 1;
      step();
      rst = 0;
      #1;
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL midrst_rvalid: got %b want 0", aux_rvalid); else n_pass++;
      n_checks++; if (cpu_stall !== 1'b0) $display("FAIL midrst_stall: got %b want 0", cpu_stall); else n_pass++;
      n_checks++; if (aux_req_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", aux_req_ready); else n_pass++;
      idle();
      step();
   endtask
`else
   task automatic test_strict_priority();
      int stall_seen = 0;
      int ready_seen = 0;
      do_reset();
      for (int c = 0; c < 100; c++) begin
         conflict();
         #1;
         if (cpu_stall !== 1'b0) stall_seen++;
         if (aux_req_ready !== 1'b0) ready_seen++;
         step();
      end
      n_checks++; if (stall_seen !== 0) $display("FAIL strict_stall: got %0d stall cycles want 0", stall_seen); else n_pass++;
      n_checks++; if (ready_seen !== 0) $display("FAIL strict_ready: got %0d accepts want 0", ready_seen); else n_pass++;
      cpu_en = 0;
      #1;
      n_checks++; if (aux_req_ready !== 1'b1) $display("FAIL strict_idle_accept: got %b want 1", aux_req_ready); else n_pass++;
      step();
      idle();
      step();
   endtask
`endif

   initial begin
      idle();
      rst = 1;
      test_reset();
      test_aux_only();
      test_idle_port();
      test_cpu_priority();
      test_back_to_back();
`ifdef DMEM_ARB_STARVE_GUARD_EN
      test_starvation();
      test_reset_mid_burst();
`else
      test_strict_priority();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
